// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetching instruction fetch queue that flushes on pointer redirect
// Optional FETCH_BYPASS_EN: forwards a response straight to the core while the queue is empty.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic [31:0] pointer,
    input  logic        advance,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_addr;
    logic [31:0]   stream_base;
    logic [CW-1:0] outstanding, outstanding_next;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   fifo_mem [DEPTH];

    logic          redirect;
    logic          rsp;
    logic          accept;
    logic          push, pop, bypass;
    logic [CW:0]   in_use;

    assign redirect = (pointer != stream_base);
    // A response with nothing outstanding belongs to no tracked request and is dropped.
    assign rsp      = mem_rvalid && (outstanding != '0);
    assign in_use   = {1'b0, count} + {1'b0, outstanding};
    assign mem_addr = fetch_addr;
    assign accept   = mem_req && mem_ack;

    always_comb begin
        state_next       = state;
        mem_req          = 1'b0;
        instr_valid      = 1'b0;
        instr_out        = 32'h0;
        push             = 1'b0;
        pop              = 1'b0;
        bypass           = 1'b0;
        if (state == RUN && !_reset && !redirect) begin
            mem_req = (in_use < DEPTH_V);
            if (count != '0) begin
                instr_valid = 1'b1;
                instr_out   = fifo_mem[rd_ptr];
                pop         = advance;
            end
`ifdef FETCH_BYPASS_EN
            else if (rsp) begin
                instr_valid = 1'b1;
                instr_out   = mem_rdata;
                bypass      = advance;
            end
`endif
            push = rsp && !bypass;
        end
        outstanding_next = outstanding + CW'(accept) - CW'(rsp);
        // Stale responses must all come back before the new stream may issue requests.
        if (redirect || state == DRAIN)
            state_next = (outstanding_next != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) begin
            state       <= RUN;
            fetch_addr  <= 32'h0;
            stream_base <= 32'h0;
            outstanding <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_addr  <= pointer;
                stream_base <= pointer;
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
            end else begin
                if (accept)
                    fetch_addr <= fetch_addr + 32'd1;
                if (pop || bypass)
                    stream_base <= stream_base + 32'd1;
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_rdata;
    end

endmodule
